// File: rtl/riscv_hazard_unit.sv
// Pipeline hazard controller: in-flight rd scoreboard for forwarding/load-use interlock plus taken-branch flush.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module riscv_hazard_unit #(
   parameter int REG_WIDTH        = 32,
   parameter int REG_ADDR_WIDTH   = 5,
   parameter int PC_WIDTH         = 32,
   parameter int DEPTH            = 3,
   parameter int LOAD_READY_STAGE = 1
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic                             id_valid,
   input  logic [REG_ADDR_WIDTH-1:0]        id_rs1_adr,
   input  logic [REG_ADDR_WIDTH-1:0]        id_rs2_adr,
   input  logic                             id_rs1_used,
   input  logic                             id_rs2_used,
   input  logic [REG_ADDR_WIDTH-1:0]        id_rd_adr,
   input  logic                             id_rd_we,
   input  logic                             id_is_load,
   input  logic [REG_WIDTH-1:0]             rf_rs1_data,
   input  logic [REG_WIDTH-1:0]             rf_rs2_data,
   input  logic [DEPTH*REG_WIDTH-1:0]       stage_rslt,
   input  logic                             br_valid,
   input  logic                             br_taken,
   input  logic [PC_WIDTH-1:0]              br_target,
   output logic [REG_WIDTH-1:0]             opd1,
   output logic [REG_WIDTH-1:0]             opd2,
   output logic [$clog2(DEPTH+1)-1:0]       fwd1_sel,
   output logic [$clog2(DEPTH+1)-1:0]       fwd2_sel,
   output logic                             stall,
   output logic                             flush,
   output logic                             redirect_valid,
   output logic [PC_WIDTH-1:0]              redirect_pc,
   output logic [31:0]                      stall_cnt,
   output logic [31:0]                      flush_cnt
);

   localparam int SEL_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]          r_vld;
   logic [DEPTH-1:0]          r_we;
   logic [DEPTH-1:0]          r_ld;
   logic [REG_ADDR_WIDTH-1:0] r_rd [DEPTH];

   logic [REG_ADDR_WIDTH-1:0] w_src_adr [2];
   logic [REG_WIDTH-1:0]      w_src_rf  [2];
   logic [1:0]                w_src_used;
   logic                      w_issue;

   assign w_src_adr[0] = id_rs1_adr;
   assign w_src_adr[1] = id_rs2_adr;
   assign w_src_rf[0]  = rf_rs1_data;
   assign w_src_rf[1]  = rf_rs2_data;
   assign w_src_used   = {id_rs2_used, id_rs1_used};

   for (genvar g = 0; g < 2; g++) begin : g_src
      logic                 w_hit;
      logic                 w_use;
      logic                 w_ld;
      logic                 w_rdy;
      logic                 w_take;
      logic                 w_hazard;
      logic [SEL_W-1:0]     w_idx1;
      logic [SEL_W-1:0]     w_sel;
      logic [REG_WIDTH-1:0] w_fwd;
      logic [REG_WIDTH-1:0] w_opd;

      // Scan oldest-to-youngest so the lowest matching slot overrides older ones.
      always_comb begin
         w_hit  = 1'b0;
         w_ld   = 1'b0;
         w_rdy  = 1'b0;
         w_take = 1'b0;
         w_idx1 = '0;
         w_fwd  = '0;
         for (int i = DEPTH - 1; i >= 0; i--) begin
            w_take = r_vld[i] && r_we[i] && (r_rd[i] == w_src_adr[g]);
            w_hit  = w_hit | w_take;
            w_ld   = w_take ? r_ld[i] : w_ld;
            w_rdy  = w_take ? (i >= LOAD_READY_STAGE) : w_rdy;
            w_idx1 = w_take ? SEL_W'(i + 1) : w_idx1;
            w_fwd  = w_take ? stage_rslt[i*REG_WIDTH +: REG_WIDTH] : w_fwd;
         end
         w_use    = w_src_used[g] && (w_src_adr[g] != '0) && w_hit;
         w_hazard = w_use && w_ld && !w_rdy;
         w_sel    = (w_use && !w_hazard) ? w_idx1 : '0;
         w_opd    = (w_sel != '0) ? w_fwd : w_src_rf[g];
      end
   end

   assign opd1           = g_src[0].w_opd;
   assign opd2           = g_src[1].w_opd;
   assign fwd1_sel       = g_src[0].w_sel;
   assign fwd2_sel       = g_src[1].w_sel;
   assign flush          = br_valid && br_taken;
   assign stall          = id_valid && (g_src[0].w_hazard || g_src[1].w_hazard) && !flush;
   assign redirect_valid = flush;
   assign redirect_pc    = br_target;
   assign w_issue        = id_valid && !stall && !flush;

   // Scoreboard shift: slot 0 takes the issuing instruction or a bubble; the last slot retires.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_vld <= '0;
         r_we  <= '0;
         r_ld  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i] <= '0;
         end
      end else begin
         r_vld   <= {r_vld[DEPTH-2:0], w_issue};
         r_we    <= {r_we[DEPTH-2:0], id_rd_we};
         r_ld    <= {r_ld[DEPTH-2:0], id_is_load};
         r_rd[0] <= id_rd_adr;
         for (int i = 1; i < DEPTH; i++) begin
            r_rd[i] <= r_rd[i-1];
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   // Saturating stall/flush event counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stall_cnt <= 32'd0;
         r_flush_cnt <= 32'd0;
      end else begin
         if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = 32'd0;
   assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Directed, table-driven bench for riscv_hazard_unit with default parameters (DEPTH=3, LOAD_READY_STAGE=1).
module tb_riscv_hazard_unit;

   logic        clk;
   logic        resetn;
   logic        id_valid;
   logic [4:0]  id_rs1_adr, id_rs2_adr, id_rd_adr;
   logic        id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
   logic [31:0] rf_rs1_data, rf_rs2_data;
   logic [95:0] stage_rslt;
   logic        br_valid, br_taken;
   logic [31:0] br_target;
   logic [31:0] opd1, opd2;
   logic [1:0]  fwd1_sel, fwd2_sel;
   logic        stall, flush, redirect_valid;
   logic [31:0] redirect_pc, stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [31:0] CNT_ON = 32'd1;
`else
   localparam logic [31:0] CNT_ON = 32'd0;
`endif

   riscv_hazard_unit dut (
      .clk(clk), .resetn(resetn), .id_valid(id_valid),
      .id_rs1_adr(id_rs1_adr), .id_rs2_adr(id_rs2_adr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd_adr(id_rd_adr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .stage_rslt(stage_rslt), .br_valid(br_valid), .br_taken(br_taken),
      .br_target(br_target), .opd1(opd1), .opd2(opd2),
      .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [4:0]  rs1, rs2;
      logic        u1, u2;
      logic [4:0]  rd;
      logic        we, ld;
      logic [31:0] rf1, rf2, s0, s1, s2;
      logic        bv, bt;
      logic [31:0] tgt;
      logic [31:0] e_opd1, e_opd2;
      logic [1:0]  e_sel1, e_sel2;
      logic        e_stall, e_flush;
      logic        c1, c2;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      id_valid    = v.vld;
      id_rs1_adr  = v.rs1;
      id_rs2_adr  = v.rs2;
      id_rs1_used = v.u1;
      id_rs2_used = v.u2;
      id_rd_adr   = v.rd;
      id_rd_we    = v.we;
      id_is_load  = v.ld;
      rf_rs1_data = v.rf1;
      rf_rs2_data = v.rf2;
      stage_rslt  = {v.s2, v.s1, v.s0};
      br_valid    = v.bv;
      br_taken    = v.bt;
      br_target   = v.tgt;
   endtask

   task automatic issue(input logic [4:0] rd, input logic ld);
      id_valid = 1'b1; id_rd_adr = rd; id_rd_we = 1'b1; id_is_load = ld;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
   endtask

   initial begin
      // Vector i is applied in cycle i; slot contents follow from the vectors before it.
      //          vld   rs1    rs2    u1    u2    rd     we    ld    rf1        rf2        s0          s1          s2          bv    bt    tgt         e_opd1      e_opd2      sel1  sel2  stl   fl    c1    c2
      tbl[0]  = '{1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 32'h111,   32'h222,   32'h1000,   32'h2000,   32'h3000,   1'b0, 1'b0, 32'h0,      32'h111,    32'h222,    2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[1]  = '{1'b1, 5'd5,  5'd3,  1'b1, 1'b1, 5'd6,  1'b1, 1'b1, 32'h111,   32'h222,   32'h10,     32'h2000,   32'h3000,   1'b0, 1'b0, 32'h0,      32'h10,     32'h222,    2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[2]  = '{1'b1, 5'd5,  5'd6,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 32'h111,   32'h222,   32'h77,     32'h20,     32'h3000,   1'b0, 1'b0, 32'h0,      32'h20,     32'h0,      2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 5'd5,  5'd6,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 32'h111,   32'h222,   32'h77,     32'hDEAD,   32'h30,     1'b0, 1'b0, 32'h0,      32'h30,     32'hDEAD,   2'd3, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[4]  = '{1'b1, 5'd6,  5'd9,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 32'h111,   32'h222,   32'h99,     32'h2000,   32'hBEEF,   1'b0, 1'b0, 32'h0,      32'hBEEF,   32'h99,     2'd3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 5'd7,  5'd9,  1'b0, 1'b0, 5'd8,  1'b1, 1'b0, 32'h111,   32'h222,   32'h1000,   32'h2000,   32'h3000,   1'b0, 1'b0, 32'h0,      32'h111,    32'h222,    2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[6]  = '{1'b1, 5'd9,  5'd0,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 32'h111,   32'h222,   32'h1000,   32'h2000,   32'h3000,   1'b0, 1'b0, 32'h0,      32'h3000,   32'h222,    2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[7]  = '{1'b1, 5'd7,  5'd8,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 32'h111,   32'h222,   32'hA,      32'hC,      32'hB,      1'b0, 1'b0, 32'h0,      32'hA,      32'hC,      2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 5'd0,  5'd7,  1'b1, 1'b1, 5'd6,  1'b1, 1'b1, 32'h0,     32'h222,   32'h55,     32'h2000,   32'h3000,   1'b0, 1'b0, 32'h0,      32'h0,      32'h2000,   2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{1'b1, 5'd6,  5'd7,  1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 32'h111,   32'h222,   32'h1000,   32'h2000,   32'h3000,   1'b1, 1'b1, 32'h100,    32'h0,      32'h3000,   2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 5'd10, 5'd6,  1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 32'h111,   32'h222,   32'h1000,   32'h2000,   32'h3000,   1'b1, 1'b0, 32'h200,    32'h111,    32'h2000,   2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 5'd11, 5'd6,  1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 32'h111,   32'h222,   32'h1000,   32'h2000,   32'h3000,   1'b0, 1'b0, 32'h0,      32'h1000,   32'h3000,   2'd1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1};

      // Reset state: no forwarding or stall, flush follows br_* even in reset.
      resetn = 1'b0;
      apply(tbl[0]);
      id_valid = 1'b0; id_rs1_adr = 5'd5; br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h40;
      #1;
      chk("reset_stall", {31'd0, stall}, 32'd0);
      chk("reset_sel1", {30'd0, fwd1_sel}, 32'd0);
      chk("reset_opd1", opd1, 32'h111);
      chk("reset_flush", {31'd0, flush}, 32'd1);
      chk("reset_stall_cnt", stall_cnt, 32'd0);
      br_valid = 1'b0; br_taken = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         apply(tbl[i]);
         #1;
         if (tbl[i].c1) chk($sformatf("v%0d_opd1", i), opd1, tbl[i].e_opd1);
         if (tbl[i].c2) chk($sformatf("v%0d_opd2", i), opd2, tbl[i].e_opd2);
         chk($sformatf("v%0d_sel1", i), {30'd0, fwd1_sel}, {30'd0, tbl[i].e_sel1});
         chk($sformatf("v%0d_sel2", i), {30'd0, fwd2_sel}, {30'd0, tbl[i].e_sel2});
         chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].e_stall});
         chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, tbl[i].e_flush});
         chk($sformatf("v%0d_redir_v", i), {31'd0, redirect_valid}, {31'd0, tbl[i].e_flush});
         chk($sformatf("v%0d_redir_pc", i), redirect_pc, tbl[i].tgt);
      end

      // One stall cycle (vector 2) and one flush cycle (vector 9) in the table.
      @(negedge clk);
      chk("stall_cnt", stall_cnt, CNT_ON);
      chk("flush_cnt", flush_cnt, CNT_ON);

      // Fill all slots (load x14 youngest), then raise a load-use stall and reset mid-cycle.
      issue(5'd12, 1'b0);
      @(negedge clk);
      issue(5'd13, 1'b0);
      @(negedge clk);
      issue(5'd14, 1'b1);
      @(negedge clk);
      id_valid = 1'b1; id_rs1_adr = 5'd14; id_rs1_used = 1'b1; id_rd_adr = 5'd16;
      rf_rs1_data = 32'h123;
      #1;
      chk("pre_rst_stall", {31'd0, stall}, 32'd1);
      chk("pre_rst_stall_cnt", stall_cnt, CNT_ON);
      #1;
      resetn = 1'b0;
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_sel1", {30'd0, fwd1_sel}, 32'd0);
      chk("rst_sel2", {30'd0, fwd2_sel}, 32'd0);
      chk("rst_opd1", opd1, 32'h123);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_flush_cnt", flush_cnt, 32'd0);

      // First issue after release is accepted on the first rising edge.
      @(negedge clk);
      resetn = 1'b1;
      issue(5'd15, 1'b0);
      @(negedge clk);
      id_valid = 1'b0; id_rs1_adr = 5'd15; id_rs1_used = 1'b1;
      stage_rslt = {32'h3, 32'h2, 32'h51};
      #1;
      chk("post_rst_sel1", {30'd0, fwd1_sel}, 32'd1);
      chk("post_rst_opd1", opd1, 32'h51);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
